// File: rtl/char_slot_scheduler.sv
// Falling-character slot table with one scan FSM serialising move / match / spawn updates.
// Define CHAR_SCHED_DEEPEST_EN to have a key remove the lowest matching character instead of the lowest-index one.
module char_slot_scheduler #(
  parameter int SLOTS     = 16,
  parameter int IDX_W     = 4,
  parameter int Y_LIMIT   = 480,
  parameter int SCORE_MAX = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             spawn_req,
  input  logic [7:0]       spawn_ascii,
  input  logic [9:0]       spawn_x,
  input  logic [2:0]       spawn_speed,
  output logic             spawn_ack,
  output logic             spawn_drop,
  input  logic             frame_tick,
  input  logic             key_valid,
  input  logic [7:0]       key_ascii,
  input  logic [IDX_W-1:0] rd_slot,
  output logic             rd_valid,
  output logic [7:0]       rd_ascii,
  output logic [9:0]       rd_x,
  output logic [9:0]       rd_y,
  output logic             hit,
  output logic [7:0]       score,
  output logic             gameover,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MOVE  = 2'd1;
  localparam logic [1:0] ST_MATCH = 2'd2;
  localparam logic [1:0] ST_SPAWN = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SLOTS - 1);
  localparam logic [10:0]      LIMIT_11  = 11'(Y_LIMIT);
  localparam logic [7:0]       SCORE_TOP = 8'(SCORE_MAX);

  logic       slot_valid [SLOTS];
  logic [7:0] slot_ascii [SLOTS];
  logic [9:0] slot_x     [SLOTS];
  logic [9:0] slot_y     [SLOTS];
  logic [2:0] slot_speed [SLOTS];

  logic [1:0] state;
  logic       enable_q;

  logic       move_pend, match_pend, spawn_pend;
  logic [7:0] key_pend;
  logic [7:0] spn_ascii;
  logic [9:0] spn_x;
  logic [2:0] spn_speed;

  // Working copies taken on state entry, so a re-latched pulse cannot alter an operation in flight.
  logic [7:0] key_cur;
  logic [7:0] new_ascii;
  logic [9:0] new_x;
  logic [2:0] new_speed;

  logic [IDX_W-1:0] scan_idx;
  logic             match_fin;
  logic             cand_found;
  logic [IDX_W-1:0] cand_idx;
`ifdef CHAR_SCHED_DEEPEST_EN
  logic [9:0]       cand_y;
`endif

  logic             take_move, take_match, take_spawn;
  logic             match_now, take, stop;
  logic [10:0]      y_sum;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;

  assign take_move  = (state == ST_IDLE) && move_pend;
  assign take_match = (state == ST_IDLE) && !move_pend && match_pend;
  assign take_spawn = (state == ST_IDLE) && !move_pend && !match_pend && spawn_pend;

  assign y_sum     = {1'b0, slot_y[scan_idx]} + {8'b0, slot_speed[scan_idx]};
  assign match_now = slot_valid[scan_idx] && (slot_ascii[scan_idx] == key_cur);

`ifdef CHAR_SCHED_DEEPEST_EN
  // Strict compare keeps the earlier (lower-index) slot on equal depth.
  assign take = match_now && (!cand_found || (slot_y[scan_idx] > cand_y));
  assign stop = (scan_idx == LAST_IDX);
`else
  assign take = match_now;
  assign stop = match_now || (scan_idx == LAST_IDX);
`endif

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!free_found && !slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        slot_valid[i] <= 1'b0;
        slot_ascii[i] <= '0;
        slot_x[i]     <= '0;
        slot_y[i]     <= '0;
        slot_speed[i] <= '0;
      end
      state      <= ST_IDLE;
      enable_q   <= 1'b0;
      move_pend  <= 1'b0;
      match_pend <= 1'b0;
      spawn_pend <= 1'b0;
      key_pend   <= '0;
      spn_ascii  <= '0;
      spn_x      <= '0;
      spn_speed  <= '0;
      key_cur    <= '0;
      new_ascii  <= '0;
      new_x      <= '0;
      new_speed  <= '0;
      scan_idx   <= '0;
      match_fin  <= 1'b0;
      cand_found <= 1'b0;
      cand_idx   <= '0;
`ifdef CHAR_SCHED_DEEPEST_EN
      cand_y     <= '0;
`endif
      spawn_ack  <= 1'b0;
      spawn_drop <= 1'b0;
      hit        <= 1'b0;
      gameover   <= 1'b0;
      if (rst) score <= '0;
    end else begin
      enable_q   <= 1'b1;
      spawn_ack  <= 1'b0;
      spawn_drop <= 1'b0;
      hit        <= 1'b0;
      if (!enable_q) score <= '0;

      move_pend  <= frame_tick | (move_pend  & ~take_move);
      match_pend <= key_valid  | (match_pend & ~take_match);
      spawn_pend <= spawn_req  | (spawn_pend & ~take_spawn);
      if (key_valid) key_pend <= key_ascii;
      if (spawn_req) begin
        spn_ascii <= spawn_ascii;
        spn_x     <= spawn_x;
        spn_speed <= spawn_speed;
      end

      case (state)
        ST_IDLE: begin
          scan_idx   <= '0;
          match_fin  <= 1'b0;
          cand_found <= 1'b0;
          if (take_move) begin
            state <= ST_MOVE;
          end else if (take_match) begin
            state   <= ST_MATCH;
            key_cur <= key_pend;
          end else if (take_spawn) begin
            state     <= ST_SPAWN;
            new_ascii <= spn_ascii;
            new_x     <= spn_x;
            new_speed <= spn_speed;
          end
        end
        ST_MOVE: begin
          if (slot_valid[scan_idx]) begin
            if (y_sum >= LIMIT_11) begin
              slot_valid[scan_idx] <= 1'b0;
              gameover             <= 1'b1;
            end else begin
              slot_y[scan_idx] <= y_sum[9:0];
            end
          end
          if (scan_idx == LAST_IDX) state <= ST_IDLE;
          else                      scan_idx <= scan_idx + 1'b1;
        end
        ST_MATCH: begin
          if (match_fin) begin
            if (cand_found) begin
              slot_valid[cand_idx] <= 1'b0;
              hit                  <= 1'b1;
              score <= (score >= SCORE_TOP) ? SCORE_TOP : score + 8'd1;
            end
            state <= ST_IDLE;
          end else begin
            if (take) begin
              cand_found <= 1'b1;
              cand_idx   <= scan_idx;
`ifdef CHAR_SCHED_DEEPEST_EN
              cand_y     <= slot_y[scan_idx];
`endif
            end
            if (stop) match_fin <= 1'b1;
            else      scan_idx  <= scan_idx + 1'b1;
          end
        end
        default: begin
          if (free_found) begin
            slot_valid[free_idx] <= 1'b1;
            slot_ascii[free_idx] <= new_ascii;
            slot_x[free_idx]     <= new_x;
            slot_y[free_idx]     <= '0;
            slot_speed[free_idx] <= new_speed;
            spawn_ack            <= 1'b1;
          end else begin
            spawn_drop <= 1'b1;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_valid = slot_valid[rd_slot];
  assign rd_ascii = slot_ascii[rd_slot];
  assign rd_x     = slot_x[rd_slot];
  assign rd_y     = slot_y[rd_slot];
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_char_slot_scheduler.sv
// Directed bench for char_slot_scheduler; honours CHAR_SCHED_DEEPEST_EN for the match-candidate case.
module tb_char_slot_scheduler;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic       spawn_req;
  logic [7:0] spawn_ascii;
  logic [9:0] spawn_x;
  logic [2:0] spawn_speed;
  logic       spawn_ack, spawn_drop;
  logic       frame_tick, key_valid;
  logic [7:0] key_ascii;
  logic [3:0] rd_slot;
  logic       rd_valid;
  logic [7:0] rd_ascii;
  logic [9:0] rd_x, rd_y;
  logic       hit;
  logic [7:0] score;
  logic       gameover, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, hit_cnt = 0, ack_cnt = 0, drop_cnt = 0;
  int hit_cyc = 0, ack_cyc = 0;
  int h0, a0, d0;

  char_slot_scheduler #(.SLOTS(16), .IDX_W(4), .Y_LIMIT(480), .SCORE_MAX(99)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .spawn_req(spawn_req), .spawn_ascii(spawn_ascii), .spawn_x(spawn_x), .spawn_speed(spawn_speed),
    .spawn_ack(spawn_ack), .spawn_drop(spawn_drop),
    .frame_tick(frame_tick), .key_valid(key_valid), .key_ascii(key_ascii),
    .rd_slot(rd_slot), .rd_valid(rd_valid), .rd_ascii(rd_ascii), .rd_x(rd_x), .rd_y(rd_y),
    .hit(hit), .score(score), .gameover(gameover), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (hit)        begin hit_cnt <= hit_cnt + 1; hit_cyc <= cyc; end
    if (spawn_ack)  begin ack_cnt <= ack_cnt + 1; ack_cyc <= cyc; end
    if (spawn_drop) drop_cnt <= drop_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_spawn(input logic [7:0] a, input logic [9:0] x, input logic [2:0] s);
    spawn_ascii = a; spawn_x = x; spawn_speed = s; spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    tick(4);
  endtask

  task automatic do_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick(20);
  endtask

  task automatic do_key(input logic [7:0] a);
    key_ascii = a; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick(22);
  endtask

  task automatic read_slot(input int s);
    rd_slot = 4'(s);
    #1;
  endtask

  task automatic restart();
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(2);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1;
    spawn_req = 0; spawn_ascii = 0; spawn_x = 0; spawn_speed = 0;
    frame_tick = 0; key_valid = 0; key_ascii = 0; rd_slot = 0;
    tick(3);
    check("rst_ack", spawn_ack, 0);
    check("rst_hit", hit, 0);
    check("rst_score", score, 0);
    check("rst_gameover", gameover, 0);
    check("rst_busy", busy, 0);
    read_slot(0);
    check("rst_valid", rd_valid, 0);
    check("rst_y", rd_y, 0);
    rst = 1'b0;
    tick(2);

    // Spawn into empty table lands in slot 0
    a0 = ack_cnt;
    do_spawn("A", 10'd100, 3'd2);
    check("t1_ack", ack_cnt - a0, 1);
    read_slot(0);
    check("t1_valid", rd_valid, 1);
    check("t1_ascii", rd_ascii, "A");
    check("t1_x", rd_x, 100);
    check("t1_y", rd_y, 0);

    // Miss boundary: 119 moves of 4 reach 476, the 120th hits exactly 480
    restart();
    do_spawn("G", 10'd10, 3'd4);
    for (int i = 0; i < 119; i++) do_frame();
    read_slot(0);
    check("t2_valid_476", rd_valid, 1);
    check("t2_y_476", rd_y, 476);
    check("t2_go_before", gameover, 0);
    do_frame();
    read_slot(0);
    check("t2_invalid", rd_valid, 0);
    check("t2_gameover", gameover, 1);
    a0 = ack_cnt;
    do_spawn("K", 10'd20, 3'd0);
    check("t2_runs_after_go", ack_cnt - a0, 1);
    check("t2_go_sticky", gameover, 1);
    restart();
    check("t2_go_cleared", gameover, 0);

    // Two 'B' at different depths
    do_spawn("B", 10'd0, 3'd1);
    do_spawn("C", 10'd8, 3'd0);
    do_spawn("D", 10'd16, 3'd0);
    do_spawn("B", 10'd24, 3'd4);
    for (int i = 0; i < 50; i++) do_frame();
    read_slot(3);
    check("t3_y3", rd_y, 200);
    check("t3_score0", score, 0);
    h0 = hit_cnt;
    do_key("B");
    check("t3_hits", hit_cnt - h0, 1);
    check("t3_score1", score, 1);
`ifdef CHAR_SCHED_DEEPEST_EN
    read_slot(0); check("t3_slot0", rd_valid, 1);
    read_slot(3); check("t3_slot3", rd_valid, 0);
`else
    read_slot(0); check("t3_slot0", rd_valid, 0);
    read_slot(3); check("t3_slot3", rd_valid, 1);
`endif
    read_slot(1); check("t3_slot1", rd_valid, 1);

    // Full table: drop, and an unmatched key
    restart();
    for (int i = 0; i < 16; i++) do_spawn(8'(8'h61 + i), 10'(i * 40), 3'd0);
    read_slot(15);
    check("t4_slot15_valid", rd_valid, 1);
    check("t4_slot15_ascii", rd_ascii, 8'h70);
    a0 = ack_cnt; d0 = drop_cnt;
    do_spawn("X", 10'd500, 3'd1);
    check("t4_drop", drop_cnt - d0, 1);
    check("t4_no_ack", ack_cnt - a0, 0);
    read_slot(0);
    check("t4_slot0_ascii", rd_ascii, 8'h61);
    h0 = hit_cnt;
    do_key("Z");
    check("t4_no_hit", hit_cnt - h0, 0);
    check("t4_score", score, 0);
    read_slot(7);
    check("t4_slot7_valid", rd_valid, 1);

    // Simultaneous requests: MOVE, then MATCH, then SPAWN
    restart();
    do_spawn("Q", 10'd1, 3'd3);
    do_spawn("R", 10'd2, 3'd2);
    h0 = hit_cnt; a0 = ack_cnt;
    frame_tick = 1'b1; key_valid = 1'b1; key_ascii = "Q";
    spawn_req = 1'b1; spawn_ascii = "S"; spawn_x = 10'd3; spawn_speed = 3'd5;
    tick();
    frame_tick = 1'b0; key_valid = 1'b0; spawn_req = 1'b0;
    tick(40);
    check("t5_hits", hit_cnt - h0, 1);
    check("t5_acks", ack_cnt - a0, 1);
    check("t5_order", (hit_cyc < ack_cyc) ? 1 : 0, 1);
    read_slot(0);
    check("t5_slot0_ascii", rd_ascii, "S");
    check("t5_slot0_y", rd_y, 0);
    read_slot(1);
    check("t5_slot1_y", rd_y, 2);
    read_slot(2);
    check("t5_slot2_free", rd_valid, 0);

    // Score saturation
    restart();
    h0 = hit_cnt;
    for (int i = 0; i < 99; i++) begin
      do_spawn("H", 10'd50, 3'd0);
      do_key("H");
    end
    check("t6_score99", score, 99);
    do_spawn("H", 10'd50, 3'd0);
    do_key("H");
    check("t6_hits", hit_cnt - h0, 100);
    check("t6_score_sat", score, 99);

    // enable low in the middle of a MOVE scan
    do_spawn("M", 10'd60, 3'd1);
    do_spawn("N", 10'd70, 3'd1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick(5);
    check("t6_busy_mid", busy, 1);
    enable = 1'b0;
    tick();
    check("t6_busy_off", busy, 0);
    check("t6_score_held", score, 99);
    check("t6_go_off", gameover, 0);
    for (int s = 0; s < 16; s++) begin
      read_slot(s);
      check("t6_empty", rd_valid, 0);
    end
    a0 = ack_cnt;
    do_spawn("W", 10'd5, 3'd0);
    check("t6_ignored", ack_cnt - a0, 0);
    enable = 1'b1;
    tick(3);
    check("t6_score_clr", score, 0);
    read_slot(0);
    check("t6_no_late_spawn", rd_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
